// File: rtl/at_cmd_handler.sv
// AT command handler: turns 1..3-byte AT read/write commands into single-byte
// register-file strobes and returns one response per command.
module at_cmd_handler #(
    parameter int unsigned MEM_DEPTH = 157
) (
    input  logic        fsm_clk,
    input  logic        rst,
    input  logic        at_cmd_valid,
    output logic        at_cmd_ready,
    input  logic        at_cmd_write,
    input  logic [7:0]  at_cmd_addr,
    input  logic [1:0]  at_cmd_len,
    input  logic [23:0] at_cmd_wdata,
    output logic        s_read,
    output logic        s_write,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    input  logic [23:0] sb_read,
    output logic        at_rsp_valid,
    input  logic        at_rsp_ready,
    output logic        at_rsp_write,
    output logic [7:0]  at_rsp_addr,
    output logic [1:0]  at_rsp_len,
    output logic [23:0] at_rsp_data,
    output logic        at_rsp_err
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StRwait,
        StCapt,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic [23:0] wdata_q, wdata_d;
    logic [23:0] data_q, data_d;
    logic        err_q, err_d;

    logic        accept;
    logic        cmd_err;
    logic        wr_last;
    logic [8:0]  end_addr;
    logic [7:0]  wr_byte;
    logic [23:0] rd_masked;

    // armed_q holds off at_cmd_ready until the first edge after reset release.
    assign accept   = (state_q == StIdle) && armed_q && at_cmd_valid;
    assign end_addr = {1'b0, at_cmd_addr} + {7'd0, at_cmd_len};
    assign cmd_err  = (at_cmd_len == 2'd0) || ({23'd0, end_addr} > MEM_DEPTH);
    assign wr_last  = (cnt_q == (len_q - 2'd1));

    always_comb begin
        wr_byte = wdata_q[23:16];
        case (cnt_q)
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            default: wr_byte = wdata_q[23:16];
        endcase
    end

    always_comb begin
        rd_masked = 24'd0;
        case (len_q)
            2'd1:    rd_masked = {16'd0, sb_read[7:0]};
            2'd2:    rd_masked = {8'd0, sb_read[15:0]};
            2'd3:    rd_masked = sb_read;
            default: rd_masked = 24'd0;
        endcase
    end

    // State register
    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_err) begin
                        state_d = StResp;
                    end else if (at_cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: if (wr_last) state_d = StResp;
            StRead:  state_d = StRwait;
            StRwait: state_d = StCapt;
            StCapt:  state_d = StResp;
            StResp:  if (at_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
            cnt_q   <= 2'd0;
            write_q <= 1'b0;
            addr_q  <= 8'd0;
            len_q   <= 2'd0;
            wdata_q <= 24'd0;
            data_q  <= 24'd0;
            err_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        armed_d = 1'b1;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d   = 2'd0;
                    write_d = at_cmd_write;
                    addr_d  = at_cmd_addr;
                    len_d   = at_cmd_len;
                    wdata_d = at_cmd_wdata;
                    data_d  = 24'd0;
                    err_d   = cmd_err;
                end
            end
            StWrite: cnt_d = wr_last ? 2'd0 : cnt_q + 2'd1;
            StCapt:  data_d = rd_masked;
            default: ;
        endcase
    end

    // Output logic; everything not driven by the current state stays 0.
    always_comb begin
        at_cmd_ready = 1'b0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = 8'd0;
        s_data       = 8'd0;
        at_rsp_valid = 1'b0;
        at_rsp_write = 1'b0;
        at_rsp_addr  = 8'd0;
        at_rsp_len   = 2'd0;
        at_rsp_data  = 24'd0;
        at_rsp_err   = 1'b0;
        unique case (state_q)
            StIdle: at_cmd_ready = armed_q;
            StWrite: begin
                s_write   = 1'b1;
                s_address = addr_q + {6'd0, cnt_q};
                s_data    = wr_byte;
            end
            StRead: begin
                s_read    = 1'b1;
                s_address = addr_q;
            end
            StResp: begin
                at_rsp_valid = 1'b1;
                at_rsp_write = write_q;
                at_rsp_addr  = addr_q;
                at_rsp_len   = len_q;
                at_rsp_data  = data_q;
                at_rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/at_cmd_handler.md
AT_CMD_HANDLER -- requirements
Module: at_cmd_handler

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 157, giving the number of addressable sideband register bytes (valid addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have fsm_clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have at_cmd_valid  input  1  AT command present.
REQ-005 SHALL have at_cmd_ready  output  1  handler can accept a command.
REQ-006 SHALL have at_cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have at_cmd_addr  input  8  starting byte address.
REQ-008 SHALL have at_cmd_len  input  2  byte count; legal values 1..3.
REQ-009 SHALL have at_cmd_wdata  input  24  write bytes; byte i is in [8i+7:8i].
REQ-010 SHALL have s_read, s_write  output  1 each  register-file strobes.
REQ-011 SHALL have s_address, s_data  output  8 each  register-file address and write byte.
REQ-012 SHALL have sb_read  input  24  register-file read data, registered one cycle after the s_read sample.
REQ-013 SHALL have at_rsp_valid  output  1, and at_rsp_ready  input  1, forming the response handshake.
REQ-014 SHALL have at_rsp_write, at_rsp_addr[7:0], at_rsp_len[1:0]  outputs  echoing the accepted command.
REQ-015 SHALL have at_rsp_data  output  24  read data, and at_rsp_err  output  1  error flag.

Function
REQ-016 SHALL implement the FSM states IDLE, WRITE, READ, RWAIT, CAPT and RESP.
REQ-017 IDLE: at_cmd_ready=1 and all other states 0; a command is accepted on the edge where at_cmd_valid and at_cmd_ready are both 1; command fields are latched on that edge.
REQ-018 Error check at acceptance: at_cmd_len==0, or the 9-bit sum at_cmd_addr+at_cmd_len > MEM_DEPTH, shall go to RESP with at_rsp_err=1 and no strobe issued.
REQ-019 Legal write: go to WRITE; a byte counter starts at 0.
REQ-020 Legal read: go to READ.
REQ-021 WRITE: s_write=1 for exactly len consecutive cycles, starting the cycle after acceptance; in cycle i, s_address=addr+i and s_data=wdata byte i.
REQ-022 WRITE shall exit to RESP after the cycle where the counter equals len-1.
REQ-023 The handler shall not filter read-only addresses; the register file ignores those writes, and the response reports err=0.
REQ-024 READ: s_read=1 and s_address=addr for exactly one cycle (cycle N, the cycle after acceptance); then go to RWAIT.
REQ-025 RWAIT: one idle cycle (N+1) while the register file registers sb_read; then go to CAPT.
REQ-026 CAPT: sample sb_read at the end of cycle N+2.
REQ-027 CAPT masking: len=1 keeps [7:0]; len=2 keeps [15:0]; len=3 keeps [23:0]; unused bytes are forced to 0.
REQ-028 CAPT shall then go to RESP.
REQ-029 s_read and s_write SHALL never be asserted in the same cycle; each is 0 in every state other than WRITE or READ respectively.
REQ-030 s_address and s_data SHALL be 0 whenever no strobe is active.
REQ-031 RESP: at_rsp_valid=1 with echo fields stable until the edge where at_rsp_ready=1; at that edge go to IDLE.
REQ-032 at_cmd_ready SHALL rise in the cycle after the response handshake; at_rsp_data=0 for writes and errors.
REQ-033 Only one command SHALL be outstanding; at_cmd_valid is ignored outside IDLE.
REQ-034 Address arithmetic SHALL be 8-bit for s_address; the range check prevents wrap, so addr+i never exceeds MEM_DEPTH-1.

Reset
REQ-035 When rst=0, asynchronously and regardless of state: FSM=IDLE, counter=0, every output=0, at_cmd_ready=0.
REQ-036 at_cmd_ready SHALL go to 1 on the first fsm_clk edge after rst deasserts.
REQ-037 A command in flight when reset is asserted SHALL be dropped without a response; any strobe is removed immediately.

Verification
REQ-038 Read addr=78, len=3, register file at reset values -> s_read a single cycle at 78; at_rsp_data=24'h053303, err=0, rsp_valid 3 cycles after acceptance.
REQ-039 Write addr=85, len=2, wdata=24'h00BBAA, then read 85 len=2 -> s_write cycles (85,AA),(86,BB); read response data 24'h00BBAA.
REQ-040 Read addr=155, len=3 -> no strobe; rsp_valid next cycle, err=1, data=0; read addr=154 len=3 -> err=0.
REQ-041 Hold at_rsp_ready=0 for 5 cycles -> rsp_valid and fields stable, cmd_ready=0, new at_cmd_valid ignored; release -> cmd_ready=1 the following cycle.
REQ-042 Assert rst during the second WRITE cycle of a len=3 write -> s_write=0 immediately, no response, only byte 0 written; cmd_ready=1 after release.
